// File: rtl/sid_envelope_follower.sv
// Envelope follower: rectifies a signed sample stream, tracks its amplitude with
// linear rate-scaled attack/release, and derives a hysteretic gate with a hold timer.
module sid_envelope_follower #(
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid_i,
    input  logic [7:0] sample_i,
    input  logic [3:0] attack_rate_i,
    input  logic [3:0] release_rate_i,
    input  logic [3:0] gate_on_thresh_i,
    input  logic [3:0] gate_off_thresh_i,
    output logic [7:0] envelope_o,
    output logic       gate_out_o,
    output logic [1:0] env_state_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StOpen    = 2'd1,
        StHold    = 2'd2,
        StRelease = 2'd3
    } state_e;

    // A zero hold length is treated as one clock.
    localparam int unsigned HoldLen  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int unsigned CntW     = (HoldLen > 1) ? $clog2(HoldLen) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(HoldLen - 1);

    logic [7:0]      mag_q, mag_d;
    logic [7:0]      env_q, env_d;
    logic [15:0]     pre_q, pre_d;
    logic [CntW-1:0] hold_q, hold_d;
    state_e          state_q, state_d;

    logic [7:0] abs_val;
    logic [7:0] on_level;
    logic [7:0] off_raw;
    logic [7:0] off_level;
    logic       gate_en;
    logic       attack_tick;
    logic       release_tick;

    // Rate r fires when the low r+1 prescaler bits are all ones.
    function automatic logic rate_tick(input logic [15:0] pre, input logic [3:0] rate);
        logic [15:0] mask;
        mask = 16'hFFFF >> (4'd15 - rate);
        return (pre & mask) == mask;
    endfunction

    // Rectify: magnitude saturated to 127, then doubled to span 0..254.
    always_comb begin
        abs_val = sample_i[7] ? (~sample_i + 8'd1) : sample_i;
        mag_d   = mag_q;
        if (sample_valid_i) begin
            mag_d = (abs_val > 8'd127) ? 8'd254 : {abs_val[6:0], 1'b0};
        end
    end

    // Free-running prescaler and rate ticks derived from it.
    always_comb begin
        pre_d        = pre_q + 16'd1;
        attack_tick  = rate_tick(pre_q, attack_rate_i);
        release_tick = rate_tick(pre_q, release_rate_i);
    end

    // Gate levels; a close level at or above the open level collapses onto it.
    always_comb begin
        on_level  = {gate_on_thresh_i, 4'h0};
        off_raw   = {gate_off_thresh_i, 4'h0};
        off_level = (off_raw >= on_level) ? on_level : off_raw;
        gate_en   = |gate_on_thresh_i;
    end

    // Envelope step: attack toward a larger magnitude, release toward a smaller one.
    // Single steps cannot overshoot mag_q since the comparison is strict.
    always_comb begin
        env_d = env_q;
        if (mag_q > env_q) begin
            if (attack_rate_i == 4'd0) begin
                env_d = mag_q;
            end else if (attack_tick) begin
                env_d = env_q + 8'd1;
            end
        end else if (mag_q < env_q) begin
            // Release is frozen while the gate is being held open.
            if ((state_q != StHold) && release_tick) begin
                env_d = env_q - 8'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= 8'd0;
            env_q <= 8'd0;
            pre_q <= 16'd0;
        end else begin
            mag_q <= mag_d;
            env_q <= env_d;
            pre_q <= pre_d;
        end
    end

    // FSM state and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // FSM next state; transitions look at the registered envelope.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!gate_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (env_q >= on_level) begin
                        state_d = StOpen;
                    end
                end
                StOpen: begin
                    if (env_q < off_level) begin
                        state_d = StHold;
                        hold_d  = HoldLoad;
                    end
                end
                StHold: begin
                    if (env_q >= on_level) begin
                        state_d = StOpen;
                    end else if (hold_q == '0) begin
                        state_d = StRelease;
                    end else begin
                        hold_d = hold_q - CntW'(1);
                    end
                end
                StRelease: begin
                    if (env_q >= on_level) begin
                        state_d = StOpen;
                    end else if (env_q == 8'd0) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decode purely from registers.
    always_comb begin
        envelope_o  = env_q;
        env_state_o = state_q;
        gate_out_o  = 1'b0;
        unique case (state_q)
            StOpen, StHold:    gate_out_o = 1'b1;
            StIdle, StRelease: gate_out_o = 1'b0;
            default:           gate_out_o = 1'b0;
        endcase
    end

endmodule
